// File: rtl/i2cmb_request_scheduler.sv
// i2cmb_request_scheduler
// Round-robin front end that turns single-byte client requests into
// Wishbone register sequences for the I2CMB master core, waits on the
// core interrupt after each command and reports status/read data.
module i2cmb_request_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [4*NUM_REQ-1:0] req_bus_i,
  input  logic [7*NUM_REQ-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]   req_rd_i,
  input  logic [8*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic                 done_o,
  output logic [1:0]           status_o,
  output logic [7:0]           rdata_o,
  output logic [1:0]           adr_o,
  output logic [7:0]           dat_o,
  input  logic [7:0]           dat_i,
  output logic                 we_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  input  logic                 ack_i,
  input  logic                 irq_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  typedef enum logic [2:0] {
    ST_ENABLE,
    ST_IDLE,
    ST_RUN,
    ST_WAIT_IRQ,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Steps of one transaction; DPR steps are plain register accesses,
  // CMD steps are CMDR writes that must be followed by an interrupt wait.
  typedef enum logic [3:0] {
    STEP_DPR_BUS,
    STEP_CMD_SETBUS,
    STEP_CMD_START,
    STEP_DPR_ADDR,
    STEP_CMD_ADDR,
    STEP_DPR_WDATA,
    STEP_CMD_WRITE,
    STEP_CMD_READ,
    STEP_DPR_RDATA,
    STEP_CMD_STOP
  } step_t;

  state_t         state;
  step_t          step;
  logic [PW-1:0]  rr_ptr;
  logic [3:0]     cur_bus;
  logic [6:0]     cur_addr;
  logic           cur_rd;
  logic [7:0]     cur_wdata;
  logic [1:0]     txn_status;
  logic [7:0]     txn_rdata;
  logic           timed_out;
  logic [CW-1:0]  wait_cnt;

  logic               pick_valid;
  int                 pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [1:0]         acc_adr;
  logic               acc_we;
  logic [7:0]         acc_dat;
  logic               step_is_cmd;

  // Round-robin pick: first requester at or after rr_ptr, wrapping around
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = 0;
    pick_onehot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = (int'(rr_ptr) + i) % NUM_REQ;
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

  // Register access the current state/step wants to perform next
  always_comb begin
    acc_adr     = ADR_CMDR;
    acc_we      = 1'b0;
    acc_dat     = 8'h00;
    step_is_cmd = 1'b0;
    case (state)
      ST_ENABLE: begin
        acc_adr = ADR_CSR;
        acc_we  = 1'b1;
        acc_dat = 8'hC0;
      end
      ST_RUN: begin
        case (step)
          STEP_DPR_BUS:    begin acc_adr = ADR_DPR;  acc_we = 1'b1; acc_dat = {4'h0, cur_bus}; end
          STEP_CMD_SETBUS: begin acc_we = 1'b1; acc_dat = 8'h06; step_is_cmd = 1'b1; end
          STEP_CMD_START:  begin acc_we = 1'b1; acc_dat = 8'h04; step_is_cmd = 1'b1; end
          STEP_DPR_ADDR:   begin acc_adr = ADR_DPR;  acc_we = 1'b1; acc_dat = {cur_addr, cur_rd}; end
          STEP_CMD_ADDR:   begin acc_we = 1'b1; acc_dat = 8'h01; step_is_cmd = 1'b1; end
          STEP_DPR_WDATA:  begin acc_adr = ADR_DPR;  acc_we = 1'b1; acc_dat = cur_wdata; end
          STEP_CMD_WRITE:  begin acc_we = 1'b1; acc_dat = 8'h01; step_is_cmd = 1'b1; end
          STEP_CMD_READ:   begin acc_we = 1'b1; acc_dat = 8'h03; step_is_cmd = 1'b1; end
          STEP_DPR_RDATA:  begin acc_adr = ADR_DPR;  acc_we = 1'b0; end
          STEP_CMD_STOP:   begin acc_we = 1'b1; acc_dat = 8'h05; step_is_cmd = 1'b1; end
          default:         begin acc_we = 1'b0; end
        endcase
      end
      default: begin
        acc_adr = ADR_CMDR;
      end
    endcase
  end

  // Main sequencer: arbitration, Wishbone accesses, irq wait and status check
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_ENABLE;
      step       <= STEP_DPR_BUS;
      rr_ptr     <= '0;
      cur_bus    <= '0;
      cur_addr   <= '0;
      cur_rd     <= 1'b0;
      cur_wdata  <= '0;
      txn_status <= 2'b00;
      txn_rdata  <= 8'h00;
      timed_out  <= 1'b0;
      wait_cnt   <= '0;
      gnt_o      <= '0;
      done_o     <= 1'b0;
      status_o   <= 2'b00;
      rdata_o    <= 8'h00;
      adr_o      <= 2'd0;
      dat_o      <= 8'h00;
      we_o       <= 1'b0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_o      <= pick_onehot;
            rr_ptr     <= PW'((pick_idx + 1) % NUM_REQ);
            cur_bus    <= req_bus_i[pick_idx*4 +: 4];
            cur_addr   <= req_addr_i[pick_idx*7 +: 7];
            cur_rd     <= req_rd_i[pick_idx];
            cur_wdata  <= req_wdata_i[pick_idx*8 +: 8];
            txn_status <= 2'b00;
            txn_rdata  <= 8'h00;
            timed_out  <= 1'b0;
            step       <= STEP_DPR_BUS;
            state      <= ST_RUN;
          end
        end
        ST_ENABLE, ST_RUN, ST_CHECK: begin
          if (!cyc_o) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= acc_we;
            adr_o <= acc_adr;
            dat_o <= acc_dat;
          end else if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            if (state == ST_ENABLE) begin
              state <= ST_IDLE;
            end else if (state == ST_RUN) begin
              if (step_is_cmd) begin
                wait_cnt <= '0;
                state    <= ST_WAIT_IRQ;
              end else if (step == STEP_DPR_RDATA) begin
                txn_rdata <= dat_i;
                step      <= STEP_CMD_STOP;
              end else begin
                step <= step_t'(step + 4'd1);
              end
            end else begin
              state <= ST_RUN;
              if (dat_i[5]) begin
                txn_status <= 2'b10;
                state      <= ST_DONE;
              end else if (step == STEP_CMD_STOP) begin
                if (dat_i[4] || !dat_i[7]) txn_status <= 2'b11;
                state <= ST_DONE;
              end else if (dat_i[4]) begin
                txn_status <= 2'b11;
                step       <= STEP_CMD_STOP;
              end else if (dat_i[6]) begin
                txn_status <= 2'b01;
                step       <= STEP_CMD_STOP;
              end else if (dat_i[7]) begin
                case (step)
                  STEP_CMD_SETBUS: step <= STEP_CMD_START;
                  STEP_CMD_START:  step <= STEP_DPR_ADDR;
                  STEP_CMD_ADDR:   step <= cur_rd ? STEP_CMD_READ : STEP_DPR_WDATA;
                  STEP_CMD_READ:   step <= STEP_DPR_RDATA;
                  default:         step <= STEP_CMD_STOP;
                endcase
              end else begin
                txn_status <= 2'b11;
                step       <= STEP_CMD_STOP;
              end
            end
          end
        end
        ST_WAIT_IRQ: begin
          if (irq_i) begin
            state <= ST_CHECK;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            txn_status <= 2'b11;
            timed_out  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done_o   <= 1'b1;
          gnt_o    <= '0;
          status_o <= txn_status;
          rdata_o  <= txn_rdata;
          state    <= timed_out ? ST_ENABLE : ST_IDLE;
        end
        default: state <= ST_ENABLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2cmb_request_scheduler.sv
// Directed bench for i2cmb_request_scheduler with a zero-wait I2CMB
// register model that raises irq a few cycles after each CMDR write.
module tb_i2cmb_request_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 40;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]   req_i;
  logic [4*NREQ-1:0] req_bus_i;
  logic [7*NREQ-1:0] req_addr_i;
  logic [NREQ-1:0]   req_rd_i;
  logic [8*NREQ-1:0] req_wdata_i;
  logic [NREQ-1:0]   gnt_o;
  logic              done_o;
  logic [1:0]        status_o;
  logic [7:0]        rdata_o;
  logic [1:0]        adr_o;
  logic [7:0]        dat_o;
  logic [7:0]        dat_i;
  logic              we_o, cyc_o, stb_o, ack_i;
  logic              irq_i = 1'b0;

  logic        irq_en    = 1'b1;
  logic        nak_mode  = 1'b0;
  logic [7:0]  dpr_resp  = 8'h00;
  logic [7:0]  last_cmd  = 8'h00;
  int          irq_delay = 0;

  logic [10:0]     acc_log[$];
  logic [NREQ-1:0] grant_log[$];
  logic [NREQ-1:0] prev_gnt = '0;
  logic [NREQ-1:0] cur_gnt  = '0;
  int              done_count = 0;

  logic [10:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  i2cmb_request_scheduler #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_bus_i(req_bus_i),
    .req_addr_i(req_addr_i), .req_rd_i(req_rd_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .status_o(status_o), .rdata_o(rdata_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk = ~clk;

  // Zero-wait slave: CMDR reads 0xC0 after an address write in NAK mode
  assign ack_i = cyc_o & stb_o;
  always_comb begin
    if (adr_o == 2'd2) dat_i = (nak_mode && last_cmd == 8'h01) ? 8'hC0 : 8'h80;
    else               dat_i = dpr_resp;
  end

  // Access/grant logger and interrupt model, evaluated away from the active edge
  always @(negedge clk) begin
    if (cyc_o && stb_o) begin
      acc_log.push_back({adr_o, we_o, we_o ? dat_o : dat_i});
      if (adr_o == 2'd2 && we_o) begin
        last_cmd  = dat_o;
        irq_delay = 3;
      end else if (adr_o == 2'd2) begin
        irq_i = 1'b0;
      end
    end else if (irq_delay > 0) begin
      irq_delay = irq_delay - 1;
      if (irq_delay == 0 && irq_en) irq_i = 1'b1;
    end
    if (gnt_o != '0 && prev_gnt == '0) grant_log.push_back(gnt_o);
    if (gnt_o != '0) cur_gnt = gnt_o;
    prev_gnt = gnt_o;
    if (done_o) done_count = done_count + 1;
  end

  function automatic logic [10:0] wr(input logic [1:0] a, input logic [7:0] d);
    return {a, 1'b1, d};
  endfunction

  function automatic logic [10:0] rd(input logic [1:0] a, input logic [7:0] d);
    return {a, 1'b0, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkSequence(input string tag, input int base);
    int n;
    n = acc_log.size() - base;
    checkOutput({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), acc_log[base + i], exp_q[i]);
  endtask

  task automatic applyStimulus(input int k, input logic [3:0] bus, input logic [6:0] addr,
                               input logic rdb, input logic [7:0] wdata);
    req_bus_i[k*4 +: 4]   = bus;
    req_addr_i[k*7 +: 7]  = addr;
    req_rd_i[k]           = rdb;
    req_wdata_i[k*8 +: 8] = wdata;
    req_i[k]              = 1'b1;
  endtask

  task automatic waitDone(input string tag, output logic [1:0] st, output logic [7:0] rdat);
    logic got;
    got  = 1'b0;
    st   = 2'bxx;
    rdat = 8'hxx;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done_o) begin
        got  = 1'b1;
        st   = status_o;
        rdat = rdata_o;
        checkOutput({tag, "_gnt_at_done"}, gnt_o, '0);
        req_i = req_i & ~cur_gnt;
      end
    end
    checkOutput({tag, "_done_seen"}, got, 1'b1);
  endtask

  initial begin
    logic [1:0] st;
    logic [7:0] rdat;
    int base, gbase, dc;

    rst_i = 1'b1;
    req_i = '0; req_bus_i = '0; req_addr_i = '0; req_rd_i = '0; req_wdata_i = '0;

    // Reset values
    #12;
    checkOutput("rst_gnt", gnt_o, '0);
    checkOutput("rst_done", done_o, 1'b0);
    checkOutput("rst_status", status_o, 2'b00);
    checkOutput("rst_rdata", rdata_o, 8'h00);
    checkOutput("rst_adr", adr_o, 2'd0);
    checkOutput("rst_dat", dat_o, 8'h00);
    checkOutput("rst_wb", {we_o, cyc_o, stb_o}, 3'b000);

    // Enable write then idle
    @(negedge clk);
    base = acc_log.size();
    rst_i = 1'b0;
    repeat (8) @(negedge clk);
    exp_q = {wr(2'd0, 8'hC0)};
    checkSequence("enable", base);
    checkOutput("idle_cyc", cyc_o, 1'b0);
    checkOutput("idle_gnt", gnt_o, '0);

    // Client 1 writes 0xA5 to 0x22 on bus 3
    base = acc_log.size();
    applyStimulus(1, 4'd3, 7'h22, 1'b0, 8'hA5);
    @(negedge clk);
    checkOutput("wr_gnt_rise", gnt_o, 4'b0010);
    checkOutput("wr_cyc_before", cyc_o, 1'b0);
    @(negedge clk);
    checkOutput("wr_first_acc", {cyc_o, we_o, adr_o, dat_o}, {1'b1, 1'b1, 2'd1, 8'h03});
    waitDone("wr", st, rdat);
    checkOutput("wr_status", st, 2'b00);
    exp_q = {wr(1, 8'h03), wr(2, 8'h06), rd(2, 8'h80), wr(2, 8'h04), rd(2, 8'h80),
             wr(1, 8'h44), wr(2, 8'h01), rd(2, 8'h80), wr(1, 8'hA5), wr(2, 8'h01),
             rd(2, 8'h80), wr(2, 8'h05), rd(2, 8'h80)};
    checkSequence("wr_seq", base);

    // Client 0 reads 0x10, slave returns 0x5A
    repeat (3) @(negedge clk);
    dpr_resp = 8'h5A;
    base = acc_log.size();
    applyStimulus(0, 4'd0, 7'h10, 1'b1, 8'h00);
    waitDone("rd", st, rdat);
    checkOutput("rd_status", st, 2'b00);
    checkOutput("rd_rdata", rdat, 8'h5A);
    exp_q = {wr(1, 8'h00), wr(2, 8'h06), rd(2, 8'h80), wr(2, 8'h04), rd(2, 8'h80),
             wr(1, 8'h21), wr(2, 8'h01), rd(2, 8'h80), wr(2, 8'h03), rd(2, 8'h80),
             rd(1, 8'h5A), wr(2, 8'h05), rd(2, 8'h80)};
    checkSequence("rd_seq", base);

    // Address NAK: stop without data phase, status 01
    repeat (3) @(negedge clk);
    nak_mode = 1'b1;
    base = acc_log.size();
    applyStimulus(2, 4'd1, 7'h33, 1'b0, 8'h77);
    waitDone("nak", st, rdat);
    checkOutput("nak_status", st, 2'b01);
    exp_q = {wr(1, 8'h01), wr(2, 8'h06), rd(2, 8'h80), wr(2, 8'h04), rd(2, 8'h80),
             wr(1, 8'h66), wr(2, 8'h01), rd(2, 8'hC0), wr(2, 8'h05), rd(2, 8'h80)};
    checkSequence("nak_seq", base);
    nak_mode = 1'b0;

    // Interrupt never arrives: timeout status then CSR re-enable
    repeat (3) @(negedge clk);
    irq_en = 1'b0;
    base = acc_log.size();
    applyStimulus(3, 4'd2, 7'h11, 1'b0, 8'h3C);
    waitDone("tmo", st, rdat);
    checkOutput("tmo_status", st, 2'b11);
    repeat (8) @(negedge clk);
    exp_q = {wr(1, 8'h02), wr(2, 8'h06), wr(0, 8'hC0)};
    checkSequence("tmo_seq", base);
    checkOutput("tmo_idle_cyc", cyc_o, 1'b0);
    irq_en = 1'b1;

    // Reset while a Wishbone access is in flight
    repeat (3) @(negedge clk);
    applyStimulus(1, 4'd5, 7'h45, 1'b0, 8'h12);
    for (int i = 0; i < 200 && !cyc_o; i++) @(negedge clk);
    checkOutput("mid_cyc_seen", cyc_o, 1'b1);
    dc = done_count;
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_cyc", {cyc_o, stb_o, we_o}, 3'b000);
    checkOutput("mid_rst_gnt", gnt_o, '0);
    req_i = '0;
    repeat (2) @(negedge clk);
    base = acc_log.size();
    rst_i = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("mid_no_done", done_count, dc);
    exp_q = {wr(0, 8'hC0)};
    checkSequence("mid_reenable", base);

    // All four clients request together from reset; client 0 re-requests
    rst_i = 1'b1;
    @(negedge clk);
    gbase = grant_log.size();
    for (int k = 0; k < NREQ; k++)
      applyStimulus(k, 4'(k), 7'(8'h50 + k), 1'b0, 8'(8'h90 + k));
    rst_i = 1'b0;
    waitDone("rr0", st, rdat);
    checkOutput("rr0_status", st, 2'b00);
    req_i[0] = 1'b1;
    for (int t = 1; t < 5; t++) begin
      waitDone($sformatf("rr%0d", t), st, rdat);
      checkOutput($sformatf("rr%0d_status", t), st, 2'b00);
    end
    checkOutput("rr_count", grant_log.size() - gbase, 5);
    if (grant_log.size() - gbase >= 5) begin
      checkOutput("rr_g0", grant_log[gbase + 0], 4'b0001);
      checkOutput("rr_g1", grant_log[gbase + 1], 4'b0010);
      checkOutput("rr_g2", grant_log[gbase + 2], 4'b0100);
      checkOutput("rr_g3", grant_log[gbase + 3], 4'b1000);
      checkOutput("rr_g4", grant_log[gbase + 4], 4'b0001);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
